// File: rtl/knn_axil_pkg.sv
// Shared definitions for the KNN accelerator AXI4-Lite register slave.
// Holds the register count, address decode position, response code,
// the register index type and a byte-strobe merge helper.
package knn_axil_pkg;

  localparam int         NUM_REGS  = 4;
  localparam int         ADDR_LSB  = 2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [1:0] reg_idx_t;

  // Replace only the bytes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/knn_axil_hold_buf.sv
// Single-entry holding buffer for one AXI channel (address or data).
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   push       : store din (ignored while clear is high)
//   clear      : empty the buffer (the held item was consumed)
//   din/dout   : stored payload
//   full       : an item is held
//   ready      : buffer can accept an item (~full)
module knn_axil_hold_buf
  import knn_axil_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             ready
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (clear) begin
      full_reg <= 1'b0;
    end else if (push) begin
      full_reg <= 1'b1;
      data_reg <= din;
    end
  end

  assign full  = full_reg;
  assign dout  = data_reg;
  assign ready = ~full_reg;

endmodule

// File: rtl/knn_axil_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers to the KNN core.
// AW and W are accepted independently and parked in one-entry buffers until
// both are present and the B slot is free; then the register is written under
// WSTRB and a one-cycle wr_pulse_o bit is raised. All responses are OKAY.
// Ports:
//   S_AXI_*    : AXI4-Lite slave interface (ACLK clock, ARESETN sync active-low)
//   slv_reg_o  : registers 0..3 concatenated, reg0 in [31:0]
//   wr_pulse_o : one-hot pulse, the cycle after a register commit
module knn_axil_reg_slave
  import knn_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]          slv_reg_o,
  output logic [NUM_REGS-1:0]             wr_pulse_o
);

  logic                up_reg;
  logic                bvalid_reg;
  logic                rvalid_reg;
  logic [31:0]         rdata_reg;
  logic [31:0]         regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] wr_pulse_reg;
  logic [NUM_REGS-1:0] wr_pulse_next;

  logic        aw_full, aw_free, w_full, w_free;
  reg_idx_t    aw_buf_idx;
  logic [31:0] w_buf_data;
  logic [3:0]  w_buf_strb;

  logic        aw_hs, w_hs, ar_hs, commit;
  reg_idx_t    wr_idx, ar_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  // Protection bits and address bits outside the index are don't-care.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = up_reg & aw_free;
  assign S_AXI_WREADY  = up_reg & w_free;
  assign S_AXI_ARREADY = up_reg & (~rvalid_reg | S_AXI_RREADY);

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  assign commit = (aw_full | aw_hs) & (w_full | w_hs) & (~bvalid_reg | S_AXI_BREADY);

  // A held item always takes precedence: a buffer is only full while the
  // matching channel is not ready, so no live handshake can race it.
  assign wr_idx  = aw_full ? aw_buf_idx : S_AXI_AWADDR[ADDR_LSB +: 2];
  assign wr_data = w_full  ? w_buf_data : S_AXI_WDATA;
  assign wr_strb = w_full  ? w_buf_strb : S_AXI_WSTRB;
  assign ar_idx  = S_AXI_ARADDR[ADDR_LSB +: 2];

  knn_axil_hold_buf #(.WIDTH(2)) u_aw_buf (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (aw_hs),
    .clear (commit),
    .din   (S_AXI_AWADDR[ADDR_LSB +: 2]),
    .dout  (aw_buf_idx),
    .full  (aw_full),
    .ready (aw_free)
  );

  knn_axil_hold_buf #(.WIDTH(36)) u_w_buf (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (w_hs),
    .clear (commit),
    .din   ({S_AXI_WSTRB, S_AXI_WDATA}),
    .dout  ({w_buf_strb, w_buf_data}),
    .full  (w_full),
    .ready (w_free)
  );

  always_comb begin
    wr_pulse_next = '0;
    if (commit) wr_pulse_next[wr_idx] = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      up_reg       <= 1'b0;
      bvalid_reg   <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
      wr_pulse_reg <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      up_reg       <= 1'b1;
      wr_pulse_reg <= wr_pulse_next;

      if (commit) begin
        regs_reg[wr_idx] <= byte_merge(regs_reg[wr_idx], wr_data, wr_strb);
        bvalid_reg       <= 1'b1;
      end else if (S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end

      // Reads sample the pre-edge register value, so a same-edge write is
      // not visible to a same-edge read.
      if (ar_hs) begin
        rdata_reg  <= regs_reg[ar_idx];
        rvalid_reg <= 1'b1;
      end else if (S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign slv_reg_o[gi*32 +: 32] = regs_reg[gi];
    end
  endgenerate

  assign wr_pulse_o   = wr_pulse_reg;
  assign S_AXI_BVALID = bvalid_reg;
  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_RVALID = rvalid_reg;
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = RESP_OKAY;

endmodule

// File: tb/tb_knn_axil_reg_slave.sv
// Self-checking bench for knn_axil_reg_slave: directed scenarios plus random
// traffic checked against an array-based register model.
module tb_knn_axil_reg_slave;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb, wr_pulse;
  logic [1:0]   bresp, rresp;
  logic [127:0] slv_reg;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [4];

  always #5 clk = ~clk;

  knn_axil_reg_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .slv_reg_o(slv_reg), .wr_pulse_o(wr_pulse)
  );

  // Reference: byte lane b of the register takes data lane b when strb[b] is 1.
  function automatic logic [31:0] ref_merge(input logic [31:0] old_v, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (d & mask);
  endfunction

  // All tasks start and end on a falling edge.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic ok, output logic [1:0] resp, output logic [3:0] pulse);
    logic aw_done, w_done;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 1;
    while (!(aw_done && w_done) && cyc < 20) begin
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(negedge clk);
      if (aw_done) awvalid = 0;
      if (w_done) wvalid = 0;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    ok = aw_done && w_done && bvalid;
    resp = bresp;
    pulse = wr_pulse;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic ok, output logic [31:0] data,
                          output logic [1:0] resp);
    logic done;
    int cyc;
    done = 0; cyc = 0;
    araddr = addr; arvalid = 1; rready = 1;
    while (!done && cyc < 20) begin
      #1;
      if (arready) done = 1;
      @(negedge clk);
      cyc++;
    end
    arvalid = 0;
    ok = done && rvalid;
    data = rdata;
    resp = rresp;
  endtask

  task automatic idle_inputs();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, slv_reg, wr_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_state: got aw/w/ar_rdy=%b%b%b bv=%b rv=%b rdata=%h regs=%h pulse=%b, required all zero",
               awready, wready, arready, bvalid, rvalid, rdata, slv_reg, wr_pulse);
    end
    aresetn = 1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL ready_before_up: got %b required 000", {awready, wready, arready});
    end
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_up: got %b required 111", {awready, wready, arready});
    end
    for (int i = 0; i < 4; i++) model[i] = 0;
  endtask

  task automatic test_seq_write_read();
    logic [31:0] vals [4];
    logic ok;
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    vals[0] = 32'h0101FFFF; vals[1] = 32'habcd0001; vals[2] = 32'hdead0011; vals[3] = 32'hbeef0011;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), vals[i], 4'hF, ok, resp, pulse);
      model[i] = vals[i];
      checks++;
      if (!ok || resp !== 2'b00 || pulse !== 4'(1 << i)) begin
        errors++;
        $display("FAIL seq_write%0d: ok=%b bresp=%b pulse=%b, required ok=1 bresp=00 pulse=%b",
                 i, ok, resp, pulse, 4'(1 << i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), ok, d, resp);
      checks++;
      if (!ok || resp !== 2'b00 || d !== model[i]) begin
        errors++;
        $display("FAIL seq_read%0d: ok=%b rresp=%b data=%h, required %h", i, ok, resp, d, model[i]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1; bready = 1;
    #1;
    checks++;
    if (wready !== 1'b1) begin
      errors++;
      $display("FAIL w_first_ready: wready=%b required 1", wready);
    end
    @(negedge clk);
    wvalid = 0;
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_buffered: wready=%b bvalid=%b required 0 0", wready, bvalid);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0 || slv_reg[95:64] !== model[2]) begin
        errors++;
        $display("FAIL w_wait_no_commit: bvalid=%b reg2=%h required 0 %h", bvalid, slv_reg[95:64], model[2]);
      end
    end
    awaddr = 4'h8; awvalid = 1;
    #1;
    @(negedge clk);
    awvalid = 0;
    model[2] = 32'h12345678;
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0100 || slv_reg[95:64] !== model[2] || wready !== 1'b1) begin
      errors++;
      $display("FAIL w_then_aw_commit: bvalid=%b pulse=%b reg2=%h wready=%b required 1 0100 %h 1",
               bvalid, wr_pulse, slv_reg[95:64], wready, model[2]);
    end
    @(negedge clk);
  endtask

  task automatic test_strobe();
    logic ok;
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    axi_write(4'h4, 32'h11223344, 4'hF, ok, resp, pulse);
    model[1] = 32'h11223344;
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010, ok, resp, pulse);
    model[1] = ref_merge(model[1], 32'hAABBCCDD, 4'b0010);
    axi_read(4'h4, ok, d, resp);
    checks++;
    if (!ok || d !== 32'h1122CC44) begin
      errors++;
      $display("FAIL strobe_readback: ok=%b data=%h required 1122cc44", ok, d);
    end
    axi_write(4'h7, 32'h99999999, 4'b0000, ok, resp, pulse);
    checks++;
    if (!ok || resp !== 2'b00 || pulse !== 4'b0010 || slv_reg[63:32] !== model[1]) begin
      errors++;
      $display("FAIL zero_strobe: ok=%b bresp=%b pulse=%b reg1=%h required 1 00 0010 %h",
               ok, resp, pulse, slv_reg[63:32], model[1]);
    end
  endtask

  task automatic test_b_backpressure();
    bready = 0;
    awaddr = 4'h0; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    model[0] = 32'h0BADF00D;
    awaddr = 4'h4; wdata = 32'h5A5A5A5A; awvalid = 1; wvalid = 1;
    #1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    checks++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL bp_buffered: awready=%b wready=%b bvalid=%b required 0 0 1", awready, wready, bvalid);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || slv_reg[63:32] !== model[1] || slv_reg[31:0] !== model[0]) begin
        errors++;
        $display("FAIL bp_hold: bvalid=%b bresp=%b reg0=%h reg1=%h required 1 00 %h %h",
                 bvalid, bresp, slv_reg[31:0], slv_reg[63:32], model[0], model[1]);
      end
    end
    bready = 1;
    @(negedge clk);
    model[1] = 32'h5A5A5A5A;
    checks++;
    if (bvalid !== 1'b1 || wr_pulse !== 4'b0010 || slv_reg[63:32] !== model[1] || awready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_commit: bvalid=%b pulse=%b reg1=%h awready=%b required 1 0010 %h 1",
               bvalid, wr_pulse, slv_reg[63:32], awready, model[1]);
    end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_b_clear: bvalid=%b required 0", bvalid);
    end
  endtask

  task automatic test_read_write_collision();
    logic ok;
    logic [1:0] resp;
    logic [31:0] d, old_v;
    old_v = model[1];
    araddr = 4'h4; arvalid = 1; rready = 1;
    awaddr = 4'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    #1;
    @(negedge clk);
    arvalid = 0; awvalid = 0; wvalid = 0;
    model[1] = 32'hCAFEF00D;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1) begin
      errors++;
      $display("FAIL collide_old_value: rvalid=%b rdata=%h bvalid=%b required 1 %h 1", rvalid, rdata, bvalid, old_v);
    end
    @(negedge clk);
    axi_read(4'h4, ok, d, resp);
    checks++;
    if (!ok || d !== model[1]) begin
      errors++;
      $display("FAIL collide_new_value: ok=%b data=%h required %h", ok, d, model[1]);
    end
  endtask

  task automatic test_back_to_back();
    awvalid = 1; wvalid = 1; wstrb = 4'hF; bready = 1;
    for (int k = 0; k < 4; k++) begin
      awaddr = 4'(k * 4); wdata = 32'hB2B00000 + 32'(k);
      @(negedge clk);
      model[k] = 32'hB2B00000 + 32'(k);
      checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'(1 << k) || slv_reg[k*32 +: 32] !== model[k]) begin
        errors++;
        $display("FAIL b2b_write%0d: bvalid=%b pulse=%b reg=%h required 1 %b %h",
                 k, bvalid, wr_pulse, slv_reg[k*32 +: 32], 4'(1 << k), model[k]);
      end
    end
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    araddr = 4'h0; arvalid = 1; rready = 1;
    for (int k = 0; k < 4; k++) begin
      araddr = 4'(k * 4);
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b1 || rdata !== model[k]) begin
        errors++;
        $display("FAIL b2b_read%0d: rvalid=%b rdata=%h required 1 %h", k, rvalid, rdata, model[k]);
      end
    end
    arvalid = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    bready = 0;
    awaddr = 4'h0; wdata = 32'h77777777; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    #1;
    @(negedge clk);
    wvalid = 0; awaddr = 4'h8;
    #1;
    @(negedge clk);
    awvalid = 0;
    checks++;
    if (bvalid !== 1'b1 || awready !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: bvalid=%b awready=%b required 1 0", bvalid, awready);
    end
    aresetn = 0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, slv_reg, wr_pulse} !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: bvalid=%b rvalid=%b regs=%h pulse=%b required all zero",
               bvalid, rvalid, slv_reg, wr_pulse);
    end
    bready = 1;
    aresetn = 1;
    for (int i = 0; i < 4; i++) model[i] = 0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after_reset: bvalid=%b awready=%b required 0 1", bvalid, awready);
    end
    axi_write(4'hC, 32'h600DD00D, 4'hF, ok, resp, pulse);
    model[3] = 32'h600DD00D;
    axi_read(4'hC, ok, d, resp);
    checks++;
    if (!ok || d !== model[3] || slv_reg[31:0] !== 32'h0 || pulse !== 4'b1000) begin
      errors++;
      $display("FAIL mid_first_write: data=%h reg0=%h pulse=%b required %h 0 1000", d, slv_reg[31:0], pulse, model[3]);
    end
  endtask

  task automatic test_random();
    logic ok;
    logic [1:0] resp;
    logic [3:0] pulse, strb, addr;
    logic [31:0] d, data;
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 3);
      addr = 4'(idx * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, ok, resp, pulse);
        model[idx] = ref_merge(model[idx], data, strb);
        checks++;
        if (!ok || resp !== 2'b00 || pulse !== 4'(1 << idx) || slv_reg[idx*32 +: 32] !== model[idx]) begin
          errors++;
          $display("FAIL rand_write%0d: addr=%h strb=%b ok=%b pulse=%b reg=%h required %h",
                   n, addr, strb, ok, pulse, slv_reg[idx*32 +: 32], model[idx]);
        end
      end else begin
        axi_read(addr, ok, d, resp);
        checks++;
        if (!ok || resp !== 2'b00 || d !== model[idx]) begin
          errors++;
          $display("FAIL rand_read%0d: addr=%h ok=%b data=%h required %h", n, addr, ok, d, model[idx]);
        end
      end
    end
  endtask

  initial begin
    aresetn = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_seq_write_read();
    test_w_before_aw();
    test_strobe();
    test_b_backpressure();
    test_read_write_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/knn_axil_reg_slave.md
# knn_axil_reg_slave

AXI4-Lite slave register file on the S00_AXI port of the KNN accelerator. It answers the master BFM or the PS with four 32-bit read/write registers, which it drives to the accelerator core. Write address and write data are accepted independently and in any order. Byte strobes are honoured. The block issues one write-commit pulse per register. Every response is OKAY.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32: data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: address width; register index is addr[3:2].

Ports:
- S_AXI_ACLK  in  1  single clock.
- S_AXI_ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  accepted and ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 each  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 each  write-data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 each  write-response handshake.
- S_AXI_ARADDR  in  ADDR_W  read address.
- S_AXI_ARPROT  in  3  accepted and ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 each  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 each  read-data handshake.
- slv_reg_o  out  128  registers 0..3 concatenated; reg0 occupies [31:0].
- wr_pulse_o  out  4  one-cycle pulse per register on commit.

## Operation
- The `up` flag is 0 in reset and is set at the first edge after S_AXI_ARESETN goes high. All readies are gated by `up`.
- The AW and W channels each have a single-entry holding buffer, tracked by aw_full and w_full.
  - AWREADY = up & ~aw_full.
  - WREADY = up & ~w_full.
- Commit occurs when all three conditions hold:
  - an address is available: aw_full, or an AW handshake this cycle;
  - data is available: w_full, or a W handshake this cycle;
  - the B slot is free: ~BVALID | BREADY.
- On commit:
  - reg[addr[3:2]] is updated byte-wise under WSTRB;
  - both buffers are cleared;
  - BVALID is set;
  - wr_pulse_o[idx] is asserted for the next cycle.
- A handshake whose partner is missing, or that is blocked by a pending B, is stored in its buffer. The buffer holds one item, so AWREADY or WREADY drops until commit.
- BVALID clears on BVALID & BREADY unless a new commit occurs at the same edge.
- Read path:
  - ARREADY = up & (~RVALID | RREADY).
  - On an AR handshake, RDATA ← reg[araddr[3:2]] and RVALID is set.
  - RVALID clears on RREADY unless a new AR handshake occurs at the same edge.
- Address decode:
  - addr[1:0] is ignored;
  - bits above [3] alias onto the four registers;
  - there is no SLVERR.
- A read and a write to the same register at the same edge return the old value.
- All-zero WSTRB commits, pulses wr_pulse_o and returns OKAY, but leaves the register unchanged.

## Timing
- Reset values:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID: 0;
  - BRESP, RRESP, RDATA: 0;
  - slv_reg_o: 0; wr_pulse_o: 0.
- Readies go high one cycle after reset is released.
- Reset asserted mid-transaction discards buffered AW/W and pending B/R, with no response.
- Write: AW and W on the same edge N with the B slot free gives register update and BVALID at N. The pulse appears in cycle N+1.
- Throughput: one write per cycle with BREADY tied high.
- Read: AR at edge N gives RDATA and RVALID valid after N. This is single-cycle latency with back-to-back reads when RREADY=1.
- Backpressure: BREADY low holds BVALID and BRESP stable. The next write is then buffered, and AWREADY and WREADY drop.

## Structure
- Package knn_axil_pkg holds:
  - NUM_REGS=4 and ADDR_LSB=2;
  - RESP_OKAY=2'b00;
  - the register index typedef.
- Sub-module knn_axil_hold_buf: single-entry valid/data holding buffer with ready = ~full. It is instantiated twice, for AW (address) and W (data + strobe).

## Test plan
- Sequential write then read of 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 at 0x0, 0x4, 0x8, 0xC. Each read returns the written data with BRESP=RRESP=0, and wr_pulse_o pulses bits 0..3 in turn.
- W presented 3 cycles before AW at 0x8 with data 0x12345678. WREADY drops after the W handshake, and the commit plus BVALID occur only at the AW handshake.
- WSTRB=4'b0010, data 0xAABBCCDD, to reg1 already holding 0x11223344. Readback is 0x1122CC44.
- BREADY held low for 5 cycles after a write. BVALID stays high, and a second AW/W is buffered with AWREADY=WREADY=0. Releasing BREADY commits the second write on the same edge.
- Read of 0x4 on the same edge as a write of 0xCAFEF00D to 0x4. RDATA returns the old value, and a subsequent read returns 0xCAFEF00D.
- Reset asserted while BVALID=1 and an AW is buffered. All outputs return to reset values, and the first write after reset lands correctly.
